spi_req_arbiter: RTL and testbench
==================================

SPI_REQ_ARBITER -- requirements
Module: spi_req_arbiter

Interface
REQ-001 Parameter NREQ, default 2: number of requesters sharing one SPI master controller.
REQ-002 Parameter TIMEOUT_CYC, default 1023: cycles to wait for master Ready; used only when SPI_ARB_TIMEOUT_EN is defined.
REQ-003 clk  input  1  sole clock; all logic on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  NREQ  requester i has a byte to send.
REQ-006 req_data  input  NREQ x 8  byte per requester.
REQ-007 req_ss  input  NREQ x 2  slave-select code per requester.
REQ-008 req_ready  output  NREQ  one-cycle accept pulse to requester i.
REQ-009 rsp_valid  output  NREQ  one-cycle pulse: rsp_data valid for requester i.
REQ-010 rsp_data  output  8  byte received for the granted requester.
REQ-011 rsp_err  output  1  one-cycle timeout pulse, coincident with rsp_valid (tied 0 without SPI_ARB_TIMEOUT_EN).
REQ-012 m_toXmit  output  8; m_strobe  output  1; m_ss  output  2  drive the master control System side.
REQ-013 m_rcvd  input  8; m_ready  input  1; m_xmitfull  input  1; m_busy  input  1  master status.
REQ-014 grant_id  output  clog2(NREQ)  index of current owner; arb_busy  output  1  high outside IDLE.

Function
REQ-015 FSM states IDLE, ISSUE, WAIT, RESP; reset state IDLE.
REQ-016 IDLE: if any req_valid and m_xmitfull=0, grant winner g, pulse req_ready[g], latch req_data[g]/req_ss[g], go ISSUE; otherwise stay IDLE.
REQ-017 Winner: round-robin, first valid index at or above rr_ptr, wrapping NREQ-1 -> 0.
REQ-018 ISSUE: m_strobe=1 for exactly one cycle with m_toXmit/m_ss = latched values; go WAIT.
REQ-019 WAIT: on m_ready=1 capture m_rcvd into rsp_data, go RESP; m_toXmit/m_ss hold latched values throughout.
REQ-020 RESP: rsp_valid[g]=1 one cycle, rr_ptr <= (g+1) mod NREQ, go IDLE.
REQ-021 Latency: grant cycle N, strobe N+1, rsp_valid one cycle after m_ready sampled high.
REQ-022 Requester holds req_valid/data/ss until req_ready; dropping req_valid before grant cancels with no transfer.
REQ-023 req_valid from other requesters during non-IDLE states ignored until return to IDLE.
REQ-024 m_xmitfull=1 in IDLE blocks all grants; m_busy is informational only.
REQ-025 At most one bit of req_ready and of rsp_valid high in any cycle.

Reset
REQ-026 rst=1 forces immediately: state IDLE, rr_ptr 0, grant_id 0, req_ready 0, rsp_valid 0, rsp_data 0, rsp_err 0, m_strobe 0, m_toXmit 0, m_ss 0, arb_busy 0, timeout counter 0.
REQ-027 Reset mid-transfer abandons it; no rsp_valid is issued for it afterwards.

Configuration
REQ-028 Macro SPI_ARB_TIMEOUT_EN defined: WAIT counts cycles; at TIMEOUT_CYC without m_ready go RESP with rsp_data=8'h00, rsp_err=1.
REQ-029 Macro undefined: no counter, WAIT waits indefinitely, rsp_err constant 0.

Structure
REQ-030 Package spi_arb_pkg holds state enum, data width 8, ss width 2 constants.
REQ-031 Sub-module spi_rr_arbiter: combinational round-robin winner from req_valid and rr_ptr, with any-valid flag.

Verification
REQ-032 Single req: req_valid[0]=1, data 8'hA5, ss 2'b01 -> req_ready[0] cycle N, m_strobe N+1 with 8'hA5/2'b01; m_ready with m_rcvd 8'h3C -> rsp_valid[0], rsp_data 8'h3C next cycle.
REQ-033 Contention: both valid continuously from reset -> grants alternate 0,1,0,1 over four transfers.
REQ-034 m_xmitfull=1 with req_valid[1]=1 for 10 cycles -> no req_ready, no strobe; clear -> grant next cycle.
REQ-035 rst asserted during WAIT -> all outputs 0 same cycle, IDLE, no rsp_valid after release.
REQ-036 SPI_ARB_TIMEOUT_EN, TIMEOUT_CYC=16, m_ready held 0 -> rsp_valid and rsp_err pulse after 16 WAIT cycles, rsp_data 8'h00.

Source files
------------

// File: rtl/spi_arb_pkg.sv
// Shared types and widths for the SPI requester arbiter.
package spi_arb_pkg;
  localparam int DATA_W = 8;
  localparam int SS_W   = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/spi_rr_arbiter.sv
// Combinational round-robin pick: first valid index at or above ptr, wrapping to 0.
// Zero latency; no flow control of its own.
module spi_rr_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]          valid,
  input  logic [idx_w(NREQ)-1:0]   ptr,
  output logic [idx_w(NREQ)-1:0]   winner,
  output logic                     any_valid
);
  localparam int IDW = idx_w(NREQ);

  always_comb begin
    int               idx;
    logic [IDW-1:0]   cand;
    idx       = 0;
    cand      = '0;
    winner    = '0;
    any_valid = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      cand = IDW'(idx);
      if (!any_valid && valid[cand]) begin
        winner    = cand;
        any_valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/spi_req_arbiter.sv
// Shares one SPI master among NREQ requesters (round-robin); strobe one cycle after grant, response one cycle after m_ready.
// m_xmitfull stalls grants; requesters hold until req_ready. SPI_ARB_TIMEOUT_EN adds a WAIT timeout (rsp_err).
module spi_req_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NREQ        = 2,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NREQ-1:0]               req_valid,
  input  logic [NREQ-1:0][DATA_W-1:0]   req_data,
  input  logic [NREQ-1:0][SS_W-1:0]     req_ss,
  output logic [NREQ-1:0]               req_ready,
  output logic [NREQ-1:0]               rsp_valid,
  output logic [DATA_W-1:0]             rsp_data,
  output logic                          rsp_err,
  output logic [DATA_W-1:0]             m_toXmit,
  output logic                          m_strobe,
  output logic [SS_W-1:0]               m_ss,
  input  logic [DATA_W-1:0]             m_rcvd,
  input  logic                          m_ready,
  input  logic                          m_xmitfull,
  input  logic                          m_busy,
  output logic [idx_w(NREQ)-1:0]        grant_id,
  output logic                          arb_busy
);
  localparam int IDW = idx_w(NREQ);

  state_t         state, state_nxt;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] win;
  logic           any_vld;
  logic           grant_fire;
  logic           timeout_hit;

  spi_rr_arbiter #(.NREQ(NREQ)) u_rr (
    .valid     (req_valid),
    .ptr       (rr_ptr),
    .winner    (win),
    .any_valid (any_vld)
  );

  // req_ready is combinational from IDLE, so it is masked while reset is held.
  always_comb begin
    state_nxt  = state;
    grant_fire = 1'b0;
    req_ready  = '0;
    case (state)
      ST_IDLE: begin
        if (!rst && any_vld && !m_xmitfull) begin
          grant_fire     = 1'b1;
          req_ready[win] = 1'b1;
          state_nxt      = ST_ISSUE;
        end
      end
      ST_ISSUE: state_nxt = ST_WAIT;
      ST_WAIT:  if (m_ready || timeout_hit) state_nxt = ST_RESP;
      ST_RESP:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < NREQ; i++) begin
      rsp_valid[i] = (state == ST_RESP) && (grant_id == IDW'(i));
    end
  end

  assign m_strobe = (state == ST_ISSUE);
  assign arb_busy = (state != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      rr_ptr   <= '0;
      grant_id <= '0;
      m_toXmit <= '0;
      m_ss     <= '0;
      rsp_data <= '0;
    end else begin
      state <= state_nxt;
      if (grant_fire) begin
        grant_id <= win;
        m_toXmit <= req_data[win];
        m_ss     <= req_ss[win];
      end
      if (state == ST_WAIT && m_ready) begin
        rsp_data <= m_rcvd;
      end else if (timeout_hit) begin
        rsp_data <= '0;
      end
      if (state == ST_RESP) begin
        rr_ptr <= (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);
      end
    end
  end

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] to_cnt;
  logic          err_q;
  logic          unused_ok;

  // m_ready in the final counted cycle wins over the timeout.
  assign timeout_hit = (state == ST_WAIT) && !m_ready && (to_cnt == CW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state == ST_WAIT && !m_ready && !timeout_hit) to_cnt <= to_cnt + CW'(1);
      else                                             to_cnt <= '0;
      if (state == ST_WAIT && m_ready) err_q <= 1'b0;
      else if (timeout_hit)            err_q <= 1'b1;
    end
  end

  assign rsp_err   = (state == ST_RESP) && err_q;
  assign unused_ok = m_busy;
`else
  logic unused_ok;
  assign timeout_hit = 1'b0;
  assign rsp_err     = 1'b0;
  assign unused_ok   = m_busy ^ (TIMEOUT_CYC == 0);
`endif
endmodule

// File: tb/tb_spi_req_arbiter.sv
// Bench for spi_req_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_spi_req_arbiter;
  import spi_arb_pkg::*;

  localparam int NREQ = 2;
  localparam int TO   = 16;

  logic                         clk = 1'b0;
  logic                         rst = 1'b1;
  logic [NREQ-1:0]              req_valid = '0;
  logic [NREQ-1:0][7:0]         req_data = '0;
  logic [NREQ-1:0][1:0]         req_ss = '0;
  logic [NREQ-1:0]              req_ready, rsp_valid;
  logic [7:0]                   rsp_data;
  logic                         rsp_err;
  logic [7:0]                   m_toXmit;
  logic                         m_strobe;
  logic [1:0]                   m_ss;
  logic [7:0]                   m_rcvd = '0;
  logic                         m_ready = 1'b0;
  logic                         m_xmitfull = 1'b0;
  logic                         m_busy = 1'b0;
  logic [idx_w(NREQ)-1:0]       grant_id;
  logic                         arb_busy;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  spi_req_arbiter #(.NREQ(NREQ), .TIMEOUT_CYC(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ss     (req_ss),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .m_toXmit   (m_toXmit),
    .m_strobe   (m_strobe),
    .m_ss       (m_ss),
    .m_rcvd     (m_rcvd),
    .m_ready    (m_ready),
    .m_xmitfull (m_xmitfull),
    .m_busy     (m_busy),
    .grant_id   (grant_id),
    .arb_busy   (arb_busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Transaction-level reference: who owns the master, how far its transfer has got.
  int              m_owner = -1;
  int              m_age   = 0;
  int              m_ptr   = 0;
  int              m_gid   = 0;
  bit              m_resp  = 1'b0;
  bit              m_err   = 1'b0;
  logic [7:0]      m_tx    = '0;
  logic [7:0]      m_rd    = '0;
  logic [1:0]      m_sx    = '0;
  logic [NREQ-1:0] acc     = '0;
`ifdef SPI_ARB_TIMEOUT_EN
  int              m_wcnt  = 0;
`endif

  always @(negedge clk) begin
    logic [NREQ-1:0] e_rdy, e_rv;
    bit              e_stb;
    int              win;
    e_rdy = '0;
    e_rv  = '0;
    e_stb = 1'b0;
    win   = -1;
    if (rst) begin
      m_owner = -1; m_age = 0; m_ptr = 0; m_gid = 0; m_resp = 1'b0; m_err = 1'b0;
      m_tx = '0; m_rd = '0; m_sx = '0; acc = '0;
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_rsp_err", rsp_err, 0);
      chk("rst_strobe", m_strobe, 0);
      chk("rst_toxmit", m_toXmit, 0);
      chk("rst_ss", m_ss, 0);
      chk("rst_grant_id", grant_id, 0);
      chk("rst_busy", arb_busy, 0);
    end else begin
      if (m_owner < 0) begin
        if (!m_xmitfull)
          for (int k = 0; k < NREQ; k++)
            if (win < 0 && req_valid[(m_ptr + k) % NREQ]) win = (m_ptr + k) % NREQ;
        if (win >= 0) e_rdy[win] = 1'b1;
      end else if (m_age == 1) begin
        e_stb = 1'b1;
      end else if (m_resp) begin
        e_rv[m_owner] = 1'b1;
      end
      chk("mdl_req_ready", req_ready, e_rdy);
      chk("mdl_strobe", m_strobe, e_stb);
      chk("mdl_rsp_valid", rsp_valid, e_rv);
      chk("mdl_rsp_err", rsp_err, m_resp && m_err);
      chk("mdl_rsp_data", rsp_data, m_rd);
      chk("mdl_toxmit", m_toXmit, m_tx);
      chk("mdl_ss", m_ss, m_sx);
      chk("mdl_grant_id", grant_id, m_gid);
      chk("mdl_busy", arb_busy, m_owner >= 0);
      acc = e_rdy;
      if (win >= 0) begin
        m_owner = win; m_age = 1; m_gid = win;
        m_tx = req_data[win]; m_sx = req_ss[win];
`ifdef SPI_ARB_TIMEOUT_EN
        m_wcnt = 0;
`endif
      end else if (m_owner >= 0) begin
        if (m_resp) begin
          m_ptr = (m_owner + 1) % NREQ; m_owner = -1; m_resp = 1'b0;
        end else if (m_age == 1) begin
          m_age = 2;
        end else if (m_ready) begin
          m_rd = m_rcvd; m_err = 1'b0; m_resp = 1'b1;
        end
`ifdef SPI_ARB_TIMEOUT_EN
        else begin
          m_wcnt++;
          if (m_wcnt == TO) begin
            m_rd = '0; m_err = 1'b1; m_resp = 1'b1;
          end
        end
`endif
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int b;
    int c;
    repeat (3) step();
    @(negedge clk);
    chk("reset_busy", arb_busy, 0);
    chk("reset_toxmit", m_toXmit, 0);
    step();
    rst = 1'b0;

    // Single request, literal timing
    req_valid = 2'b01; req_data[0] = 8'hA5; req_ss[0] = 2'b01;
    @(negedge clk);
    chk("single_ready", req_ready, 2'b01);
    step();
    req_valid = 2'b00;
    @(negedge clk);
    chk("single_strobe", m_strobe, 1);
    chk("single_toxmit", m_toXmit, 8'hA5);
    chk("single_ss", m_ss, 2'b01);
    step();
    @(negedge clk);
    chk("single_wait_nostrobe", m_strobe, 0);
    chk("single_wait_busy", arb_busy, 1);
    step();
    m_ready = 1'b1; m_rcvd = 8'h3C;
    step();
    m_ready = 1'b0;
    @(negedge clk);
    chk("single_rsp_valid", rsp_valid, 2'b01);
    chk("single_rsp_data", rsp_data, 8'h3C);
    step();
    @(negedge clk);
    chk("single_idle", arb_busy, 0);

    // Full master blocks grants
    step();
    req_valid = 2'b10; req_data[1] = 8'h5A; req_ss[1] = 2'b10; m_xmitfull = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("full_no_ready", req_ready, 0);
      chk("full_no_strobe", m_strobe, 0);
      step();
    end
    m_xmitfull = 1'b0;
    @(negedge clk);
    chk("full_clear_ready", req_ready, 2'b10);
    step();
    req_valid = 2'b00;
    @(negedge clk);
    chk("full_toxmit", m_toXmit, 8'h5A);
    step();
    m_ready = 1'b1; m_rcvd = 8'h77;
    step();
    m_ready = 1'b0;
    @(negedge clk);
    chk("full_rsp_valid", rsp_valid, 2'b10);
    step();

    // Contention from reset: grants alternate 0,1,0,1
    rst = 1'b1;
    req_valid = 2'b11; req_data[0] = 8'h10; req_data[1] = 8'h21;
    step();
    step();
    rst = 1'b0; m_ready = 1'b1;
    for (int t = 0; t < 4; t++) begin
      b = 0;
      @(negedge clk);
      while (req_ready == 0 && b < 20) begin
        @(negedge clk);
        b++;
      end
      chk("rr_grant", req_ready, (t % 2 == 0) ? 2 'b01 : 2'b10);
    end
    step();
    req_valid = 2'b00;
    repeat (4) step();
    m_ready = 1'b0;

    // Reset during WAIT abandons the transfer
    req_valid = 2'b01; req_data[0] = 8'h11; req_ss[0] = 2'b11;
    step();
    req_valid = 2'b00;
    step();
    #2 rst = 1'b1;
    #1;
    chk("rstwait_busy", arb_busy, 0);
    chk("rstwait_toxmit", m_toXmit, 0);
    chk("rstwait_ss", m_ss, 0);
    chk("rstwait_rsp_data", rsp_data, 0);
    chk("rstwait_rsp_valid", rsp_valid, 0);
    m_ready = 1'b1; m_rcvd = 8'hEE;
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rstwait_no_rsp", rsp_valid, 0);
      chk("rstwait_idle", arb_busy, 0);
      step();
    end
    m_ready = 1'b0;

`ifdef SPI_ARB_TIMEOUT_EN
    req_valid = 2'b10; req_data[1] = 8'h99;
    @(negedge clk);
    chk("to_grant", req_ready, 2'b10);
    step();
    req_valid = 2'b00;
    c = 1;
    @(negedge clk);
    while (rsp_valid == 0 && c < 40) begin
      @(negedge clk);
      c++;
    end
    chk("to_latency", c, 18);
    chk("to_rsp_err", rsp_err, 1);
    chk("to_rsp_data", rsp_data, 0);
    step();
`endif

    // Randomized traffic against the model
    for (int n = 0; n < 4000; n++) begin
      step();
      rst = ($urandom_range(0, 299) == 0);
      for (int i = 0; i < NREQ; i++) begin
        if (acc[i] || (!req_valid[i] && $urandom_range(0, 2) == 0)) begin
          req_valid[i] = acc[i] ? 1'($urandom_range(0, 1)) : 1'b1;
          req_data[i]  = 8'($urandom);
          req_ss[i]    = 2'($urandom);
        end else if (req_valid[i] && $urandom_range(0, 29) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      m_ready    = ($urandom_range(0, 3) == 0);
      m_rcvd     = 8'($urandom);
      m_xmitfull = ($urandom_range(0, 5) == 0);
      m_busy     = 1'($urandom);
    end
    step();
    rst = 1'b0;
    repeat (2) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
